// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
//
// Read-side client of the triple-buffer bank arbiter. On each VGA vsync it
// fetches one full frame from the SDRAM bank currently granted to VGA. It
// splits the frame into burst reads and only issues a burst when the
// downstream line FIFO has room for all of it.
//
// Optional statistics: define VGA_FRAME_STAT_EN to enable the frame_cnt_o
// and ovr_cnt_o counters. When it is undefined, both outputs are tied to 0.
//
// Handshake: rd_req_o is a level that rises in REQ. rd_bank_o, rd_addr_o and
// rd_len_o are held stable while rd_req_o is high. The controller accepts
// the request with a one-cycle rd_ack_i, and rd_req_o drops on the next
// cycle. A one-cycle rd_done_i later marks the last word of that burst as
// written into the FIFO. rd_ack_i is ignored outside REQ, and rd_done_i is
// ignored outside WAIT.
//
// Ports:
//   clk            133 MHz SDRAM-domain clock
//   rst_133        asynchronous active-low reset
//   vsync_async_i  VGA vsync, active high, pixel-clock domain (unsynchronised)
//   vga_bank_i     bank granted to VGA; sampled once per frame in LATCH
//   fifo_usedw_i   write-side fill count of the downstream FIFO
//   rd_req_o       burst read request (level until rd_ack_i)
//   rd_ack_i       controller accepted the request (1-cycle pulse)
//   rd_done_i      last word of the accepted burst is in the FIFO (pulse)
//   rd_bank_o      bank of the request
//   rd_addr_o      start word address within the bank
//   rd_len_o       number of words in this burst
//   fifo_clr_o     1-cycle FIFO flush at frame start
//   vga_rise_o     high while a frame fetch is in progress; its falling
//                  edge tells the arbiter the bank may be switched
//   frame_ovr_o    1-cycle pulse when vsync arrives during a fetch
//   frame_cnt_o    completed-frame count (statistics build only)
//   ovr_cnt_o      saturating overrun count (statistics build only)
//   state_o        current FSM state, for debug visibility
// ---------------------------------------------------------------------------
module vga_frame_reader #(
  parameter int H_PIX      = 640,
  parameter int V_LINES    = 480,
  parameter int BURST_LEN  = 256,
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = 22,
  parameter int LEN_W      = 9
) (
  input  logic                          clk,
  input  logic                          rst_133,
  input  logic                          vsync_async_i,
  input  logic [1:0]                    vga_bank_i,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_usedw_i,
  output logic                          rd_req_o,
  input  logic                          rd_ack_i,
  input  logic                          rd_done_i,
  output logic [1:0]                    rd_bank_o,
  output logic [ADDR_W-1:0]             rd_addr_o,
  output logic [LEN_W-1:0]              rd_len_o,
  output logic                          fifo_clr_o,
  output logic                          vga_rise_o,
  output logic                          frame_ovr_o,
  output logic [15:0]                   frame_cnt_o,
  output logic [7:0]                    ovr_cnt_o,
  output logic [2:0]                    state_o
);

  localparam int FRAME_WORDS = H_PIX * V_LINES;
  localparam int REM_W       = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_CHECK = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q;
  logic                pending_q;
  logic [REM_W-1:0]    rem_q;
  logic                rd_req_q;
  logic [1:0]          rd_bank_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [LEN_W-1:0]    rd_len_q;
  logic                fifo_clr_q;
  logic                vga_rise_q;
  logic                frame_ovr_q;

  // Two-flop synchroniser followed by an edge-detect flop.
  logic sync1_q, sync2_q, sync3_q;
  logic vs_start;
  logic ovr_evt;

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= vsync_async_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign vs_start = sync2_q & ~sync3_q;
  // A vsync that lands in any state other than IDLE (DONE included)
  // is remembered and replayed as soon as the current frame completes.
  assign ovr_evt  = vs_start && (state_q != S_IDLE);

  // Next-value computation for the burst sizing and address stepping.
  logic [LEN_W-1:0]  burst_len_d;
  logic              fits_d;
  logic [REM_W-1:0]  rem_next_d;
  logic [ADDR_W-1:0] addr_next_d;

  always_comb begin
    burst_len_d = LEN_W'(BURST_LEN);
    // The last burst of a frame is shortened so it never crosses the frame end.
    if (32'(rem_q) < BURST_LEN) begin
      burst_len_d = LEN_W'(rem_q);
    end
    fits_d      = (32'(fifo_usedw_i) + 32'(burst_len_d)) <= FIFO_DEPTH;
    rem_next_d  = rem_q - REM_W'(rd_len_q);
    addr_next_d = rd_addr_q + ADDR_W'(rd_len_q);
  end

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      rem_q       <= '0;
      rd_req_q    <= 1'b0;
      rd_bank_q   <= 2'b00;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      fifo_clr_q  <= 1'b0;
      vga_rise_q  <= 1'b0;
      frame_ovr_q <= 1'b0;
    end else begin
      fifo_clr_q  <= 1'b0;
      frame_ovr_q <= ovr_evt;
      if (ovr_evt) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (vs_start || pending_q) begin
            state_q    <= S_LATCH;
            pending_q  <= 1'b0;
            // Raised on entry so the flush is visible while in LATCH.
            fifo_clr_q <= 1'b1;
          end
        end

        S_LATCH: begin
          rd_bank_q  <= vga_bank_i;
          rd_addr_q  <= '0;
          rem_q      <= REM_W'(FRAME_WORDS);
          vga_rise_q <= 1'b1;
          state_q    <= S_CHECK;
        end

        S_CHECK: begin
          if (fits_d) begin
            rd_len_q <= burst_len_d;
            rd_req_q <= 1'b1;
            state_q  <= S_REQ;
          end
        end

        S_REQ: begin
          if (rd_ack_i) begin
            rd_req_q <= 1'b0;
            state_q  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (rd_done_i) begin
            rd_addr_q <= addr_next_d;
            rem_q     <= rem_next_d;
            state_q   <= (rem_next_d == '0) ? S_DONE : S_CHECK;
          end
        end

        S_DONE: begin
          vga_rise_q <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_req_o    = rd_req_q;
  assign rd_bank_o   = rd_bank_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_len_o    = rd_len_q;
  assign fifo_clr_o  = fifo_clr_q;
  assign vga_rise_o  = vga_rise_q;
  assign frame_ovr_o = frame_ovr_q;
  assign state_o     = state_q;

`ifdef VGA_FRAME_STAT_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  ovr_cnt_q;

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      if (state_q == S_DONE) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (frame_ovr_q && (ovr_cnt_q != 8'hFF)) begin
        ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign ovr_cnt_o   = ovr_cnt_q;
`else
  assign frame_cnt_o = 16'd0;
  assign ovr_cnt_o   = 8'd0;
`endif

endmodule

// File: tb/tb_vga_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_reader
//
// Instance A is an 8x4 frame (32 words) with 8-word bursts and a 32-word FIFO.
// Instance B is a 5x4 frame (20 words), whose last burst is shortened.
// Expected requests are packed as {bank[1:0], addr[21:0], len[8:0]}.
// ---------------------------------------------------------------------------
module tb_vga_frame_reader;

  localparam int ADDR_W = 22;
  localparam int LEN_W  = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_133 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic              vsync_a = 1'b0;
  logic [1:0]        bank_a  = 2'b10;
  logic [5:0]        usedw_a = 6'd0;
  logic              ack_a   = 1'b0;
  logic              done_a  = 1'b0;
  logic              rd_req_a, fifo_clr_a, vga_rise_a, frame_ovr_a;
  logic [1:0]        rd_bank_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [LEN_W-1:0]  rd_len_a;
  logic [15:0]       frame_cnt_a;
  logic [7:0]        ovr_cnt_a;
  logic [2:0]        state_a;

  vga_frame_reader #(
    .H_PIX(8), .V_LINES(4), .BURST_LEN(8), .FIFO_DEPTH(32),
    .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut_a (
    .clk(clk), .rst_133(rst_133), .vsync_async_i(vsync_a),
    .vga_bank_i(bank_a), .fifo_usedw_i(usedw_a),
    .rd_req_o(rd_req_a), .rd_ack_i(ack_a), .rd_done_i(done_a),
    .rd_bank_o(rd_bank_a), .rd_addr_o(rd_addr_a), .rd_len_o(rd_len_a),
    .fifo_clr_o(fifo_clr_a), .vga_rise_o(vga_rise_a), .frame_ovr_o(frame_ovr_a),
    .frame_cnt_o(frame_cnt_a), .ovr_cnt_o(ovr_cnt_a), .state_o(state_a)
  );

  // ---------------- instance B ----------------
  logic              vsync_b = 1'b0;
  logic [1:0]        bank_b  = 2'b01;
  logic [5:0]        usedw_b = 6'd0;
  logic              ack_b   = 1'b0;
  logic              done_b  = 1'b0;
  logic              rd_req_b, fifo_clr_b, vga_rise_b, frame_ovr_b;
  logic [1:0]        rd_bank_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [LEN_W-1:0]  rd_len_b;
  logic [15:0]       frame_cnt_b;
  logic [7:0]        ovr_cnt_b;
  logic [2:0]        state_b;

  vga_frame_reader #(
    .H_PIX(5), .V_LINES(4), .BURST_LEN(8), .FIFO_DEPTH(32),
    .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut_b (
    .clk(clk), .rst_133(rst_133), .vsync_async_i(vsync_b),
    .vga_bank_i(bank_b), .fifo_usedw_i(usedw_b),
    .rd_req_o(rd_req_b), .rd_ack_i(ack_b), .rd_done_i(done_b),
    .rd_bank_o(rd_bank_b), .rd_addr_o(rd_addr_b), .rd_len_o(rd_len_b),
    .fifo_clr_o(fifo_clr_b), .vga_rise_o(vga_rise_b), .frame_ovr_o(frame_ovr_b),
    .frame_cnt_o(frame_cnt_b), .ovr_cnt_o(ovr_cnt_b), .state_o(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  logic [32:0] exp_b_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] pack_req(input int bank, input int addr, input int len);
    return {2'(bank), 22'(addr), 9'(len)};
  endfunction

  // ---------------- monitor for instance A ----------------
  int clr_cnt = 0, clr_cyc = 0, ovr_pulses = 0, frames_done = 0;
  int fall_cyc = 0, rise_cyc = 0, gap_cyc = 0;
  logic prev_rise = 1'b0;

  always @(negedge clk) begin
    if (rst_133) begin
      if (fifo_clr_a) begin
        clr_cnt++;
        clr_cyc = cyc;
      end
      if (frame_ovr_a) ovr_pulses++;
      if (prev_rise && !vga_rise_a) begin
        frames_done++;
        fall_cyc = cyc;
      end
      if (!prev_rise && vga_rise_a) begin
        rise_cyc = cyc;
        gap_cyc  = cyc - fall_cyc;
      end
      prev_rise = vga_rise_a;
    end else begin
      prev_rise = 1'b0;
    end
  end

  // ---------------- SDRAM controller model for instance A ----------------
  int ack_delay = 0, done_delay = 2;
  int ack_cnt = 0, done_cyc = 0;
  logic in_wait = 1'b0;

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_133 && rd_req_a) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_req", rd_req_a, 0);
        end else begin
          for (int i = 0; i < ack_delay; i++) begin
            check_eq("hold_req",  rd_req_a, 1);
            check_eq("hold_addr", rd_addr_a, exp_q[0][30:9]);
            check_eq("hold_len",  rd_len_a,  exp_q[0][8:0]);
            @(negedge clk);
          end
          e = exp_q.pop_front();
          check_eq("req_bank", rd_bank_a, e[32:31]);
          check_eq("req_addr", rd_addr_a, e[30:9]);
          check_eq("req_len",  rd_len_a,  e[8:0]);
          ack_a = 1'b1;
          @(negedge clk);
          ack_a = 1'b0;
          ack_cnt++;
          check_eq("req_drop", rd_req_a, 0);
          in_wait = 1'b1;
          repeat (done_delay) @(negedge clk);
          done_a   = 1'b1;
          done_cyc = cyc;
          @(negedge clk);
          done_a  = 1'b0;
          in_wait = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_vsync_a();
    vsync_a = 1'b1;
    repeat (4) @(negedge clk);
    vsync_a = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_frame_a();
    for (int k = 0; k < 4; k++) exp_q.push_back(pack_req(2, k * 8, 8));
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 400 && frames_done < target; i++) @(negedge clk);
    check_eq("frame_done_timeout", frames_done >= target, 1);
  endtask

  task automatic serve_b_burst();
    logic [32:0] e;
    for (int i = 0; i < 100 && !rd_req_b; i++) @(negedge clk);
    if (!rd_req_b) begin
      check_eq("b_req_timeout", rd_req_b, 1);
    end else begin
      e = exp_b_q.pop_front();
      check_eq("b_req_bank", rd_bank_b, e[32:31]);
      check_eq("b_req_addr", rd_addr_b, e[30:9]);
      check_eq("b_req_len",  rd_len_b,  e[8:0]);
      ack_b = 1'b1;
      @(negedge clk);
      ack_b = 1'b0;
      check_eq("b_req_drop", rd_req_b, 0);
      repeat (2) @(negedge clk);
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base_clr, base_ack, base_frames, base_ovr, hits;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_req",   rd_req_a,    0);
    check_eq("rst_bank",  rd_bank_a,   0);
    check_eq("rst_addr",  rd_addr_a,   0);
    check_eq("rst_len",   rd_len_a,    0);
    check_eq("rst_clr",   fifo_clr_a,  0);
    check_eq("rst_rise",  vga_rise_a,  0);
    check_eq("rst_ovr",   frame_ovr_a, 0);
    check_eq("rst_fcnt",  frame_cnt_a, 0);
    check_eq("rst_ocnt",  ovr_cnt_a,   0);
    check_eq("rst_state", state_a,     0);
    #1 rst_133 = 1'b1;
    repeat (3) @(negedge clk);

    // Instance B: 20-word frame split into 8, 8, 4
    exp_b_q.push_back(pack_req(1, 0, 8));
    exp_b_q.push_back(pack_req(1, 8, 8));
    exp_b_q.push_back(pack_req(1, 16, 4));
    vsync_b = 1'b1;
    repeat (4) @(negedge clk);
    vsync_b = 1'b0;
    for (int k = 0; k < 3; k++) serve_b_burst();
    for (int i = 0; i < 10 && vga_rise_b; i++) @(negedge clk);
    check_eq("b_rise_fall", vga_rise_b, 0);
    check_eq("b_queue_empty", exp_b_q.size(), 0);

    // Test 1: plain frame, 4 bursts
    base_clr = clr_cnt; base_ack = ack_cnt; base_frames = frames_done;
    push_frame_a();
    pulse_vsync_a();
    wait_frames(base_frames + 1);
    repeat (2) @(negedge clk);
    check_eq("t1_clr_once",     clr_cnt - base_clr, 1);
    check_eq("t1_four_reqs",    ack_cnt - base_ack, 4);
    check_eq("t1_rise_after_clr", rise_cyc - clr_cyc, 1);
    check_eq("t1_fall_after_done", fall_cyc - done_cyc, 2);
    check_eq("t1_queue_empty",  exp_q.size(), 0);
    check_eq("t1_rise_low",     vga_rise_a, 0);
`ifdef VGA_FRAME_STAT_EN
    check_eq("t1_frame_cnt", frame_cnt_a, 1);
    check_eq("t1_ovr_cnt",   ovr_cnt_a,   0);
`else
    check_eq("t1_frame_cnt_tied", frame_cnt_a, 0);
    check_eq("t1_ovr_cnt_tied",   ovr_cnt_a,   0);
`endif

    // Test 2: FIFO nearly full holds off requests
    base_frames = frames_done;
    usedw_a = 6'd25;
    push_frame_a();
    pulse_vsync_a();
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_req_a) hits++;
    end
    check_eq("t2_stall_no_req", hits, 0);
    usedw_a = 6'd24;
    @(negedge clk);
    check_eq("t2_req_after_room", rd_req_a, 1);
    wait_frames(base_frames + 1);
    usedw_a = 6'd0;
    repeat (2) @(negedge clk);

    // Test 3: delayed acknowledge, request held stable
    base_frames = frames_done;
    ack_delay = 5;
    push_frame_a();
    pulse_vsync_a();
    wait_frames(base_frames + 1);
    ack_delay = 0;
    repeat (2) @(negedge clk);
    check_eq("t3_queue_empty", exp_q.size(), 0);

    // Test 4: second vsync during burst 2
    base_clr = clr_cnt; base_ack = ack_cnt; base_frames = frames_done; base_ovr = ovr_pulses;
    push_frame_a();
    pulse_vsync_a();
    for (int i = 0; i < 200 && ack_cnt < base_ack + 1; i++) @(negedge clk);
    push_frame_a();
    pulse_vsync_a();
    wait_frames(base_frames + 2);
    repeat (2) @(negedge clk);
    check_eq("t4_ovr_once",   ovr_pulses - base_ovr, 1);
    check_eq("t4_clr_twice",  clr_cnt - base_clr, 2);
    check_eq("t4_eight_reqs", ack_cnt - base_ack, 8);
    check_eq("t4_rise_gap",   gap_cyc, 2);
    check_eq("t4_queue_empty", exp_q.size(), 0);
`ifdef VGA_FRAME_STAT_EN
    check_eq("t4_ovr_cnt",   ovr_cnt_a,   1);
    check_eq("t4_frame_cnt", frame_cnt_a, frames_done);
`endif

    // Test 5: asynchronous reset during WAIT
    done_delay = 15;
    push_frame_a();
    pulse_vsync_a();
    for (int i = 0; i < 100 && !in_wait; i++) @(negedge clk);
    check_eq("t5_reach_wait", in_wait, 1);
    repeat (2) @(negedge clk);
    #2 rst_133 = 1'b0;
    #1;
    check_eq("t5_rst_req",   rd_req_a,    0);
    check_eq("t5_rst_rise",  vga_rise_a,  0);
    check_eq("t5_rst_addr",  rd_addr_a,   0);
    check_eq("t5_rst_len",   rd_len_a,    0);
    check_eq("t5_rst_bank",  rd_bank_a,   0);
    check_eq("t5_rst_state", state_a,     0);
    check_eq("t5_rst_fcnt",  frame_cnt_a, 0);
    repeat (2) @(negedge clk);
    #1 rst_133 = 1'b1;
    exp_q.delete();
    done_delay = 2;
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_req_a) hits++;
    end
    check_eq("t5_no_req_after_rst", hits, 0);
    check_eq("t5_rise_idle", vga_rise_a, 0);

    // Recovery: the next vsync fetches a full frame again
    base_frames = frames_done; base_ack = ack_cnt;
    push_frame_a();
    pulse_vsync_a();
    wait_frames(base_frames + 1);
    repeat (2) @(negedge clk);
    check_eq("t6_four_reqs",   ack_cnt - base_ack, 4);
    check_eq("t6_queue_empty", exp_q.size(), 0);
`ifdef VGA_FRAME_STAT_EN
    check_eq("t6_frame_cnt", frame_cnt_a, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
